// File: rtl/puf_race_arbiter.sv
// puf_race_arbiter: sequences one arbiter-PUF measurement. It latches a challenge
// onto the delay-path muxes, clears and then arms the two post-mux counters, and
// decides which counter finished first. The result leaves as one response bit
// with tie/timeout qualifiers.
//
// Handshake: resp_valid rises together with a stable response and stays high,
// with resp_bit/resp_tie/resp_timeout/mux_sel frozen, until the edge where
// resp_ready is also high. That edge is the transfer, and the response is then
// withdrawn.
module puf_race_arbiter #(
    parameter int CHAL_W     = 8,
    parameter int CLR_CYCLES = 2,
    parameter int SETTLE_CYC = 4,
    parameter int TIMEOUT_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    output logic              busy,
    output logic [CHAL_W-1:0] mux_sel,
    output logic              cnt_reset,
    output logic              cnt_enable,
    input  logic              finished_a,
    input  logic              finished_b,
    output logic              resp_bit,
    output logic              resp_tie,
    output logic              resp_timeout,
    output logic              resp_valid,
    input  logic              resp_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RACE   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    // Phase counter must hold the longer of the CLEAR and SETTLE durations.
    localparam int PH_MAX = (CLR_CYCLES > SETTLE_CYC) ? CLR_CYCLES : SETTLE_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;

    localparam logic [PH_W-1:0]      CLR_LAST    = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0]      SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0]      PH_ONE      = PH_W'(1);
    localparam logic [TIMEOUT_W-1:0] TIMER_ONE   = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TIMER_MAX   = {TIMEOUT_W{1'b1}};

    // FSM state is kept as a named register so checkers can bind to it directly.
    logic [2:0]           state;
    logic [PH_W-1:0]      phase_cnt;
    logic [TIMEOUT_W-1:0] timer;
    logic [TIMEOUT_W-1:0] timer_next;

    logic a_meta;
    logic a_sync;
    logic b_meta;
    logic b_sync;
    logic fa;
    logic fb;

    // Two-flop synchronizers bring the counters' finished flags into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_meta <= 1'b0;
            a_sync <= 1'b0;
            b_meta <= 1'b0;
            b_sync <= 1'b0;
        end else begin
            a_meta <= finished_a;
            a_sync <= a_meta;
            b_meta <= finished_b;
            b_sync <= b_meta;
        end
    end

    assign fa = a_sync;
    assign fb = b_sync;

    // The timeout compares the incremented value, so cnt_enable is high for
    // exactly 2^TIMEOUT_W-1 cycles when neither flag arrives.
    assign timer_next = timer + TIMER_ONE;

    // Main measurement sequencer. Every output is a register written only here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            phase_cnt    <= '0;
            timer        <= '0;
            busy         <= 1'b0;
            mux_sel      <= '0;
            cnt_reset    <= 1'b1;
            cnt_enable   <= 1'b0;
            resp_bit     <= 1'b0;
            resp_tie     <= 1'b0;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_reset  <= 1'b1;
                    cnt_enable <= 1'b0;
                    if (start) begin
                        mux_sel   <= challenge;
                        busy      <= 1'b1;
                        phase_cnt <= '0;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    // Counters are held in reset while the new challenge propagates.
                    if (phase_cnt == CLR_LAST) begin
                        phase_cnt <= '0;
                        cnt_reset <= 1'b0;
                        state     <= S_SETTLE;
                    end else begin
                        phase_cnt <= phase_cnt + PH_ONE;
                    end
                end
                S_SETTLE: begin
                    // Long enough for stale flags to leave the synchronizers.
                    timer <= '0;
                    if (phase_cnt == SETTLE_LAST) begin
                        phase_cnt  <= '0;
                        cnt_enable <= 1'b1;
                        state      <= S_RACE;
                    end else begin
                        phase_cnt <= phase_cnt + PH_ONE;
                    end
                end
                S_RACE: begin
                    timer <= timer_next;
                    // Any flag takes priority over a timeout in the same cycle.
                    if (fa || fb || (timer_next == TIMER_MAX)) begin
                        resp_bit     <= fa & ~fb;
                        resp_tie     <= fa & fb;
                        resp_timeout <= ~fa & ~fb;
                        cnt_enable   <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    // Counters stay out of reset so their values remain readable.
                    if (resp_ready) begin
                        resp_valid   <= 1'b0;
                        resp_bit     <= 1'b0;
                        resp_tie     <= 1'b0;
                        resp_timeout <= 1'b0;
                        busy         <= 1'b0;
                        cnt_reset    <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    cnt_reset  <= 1'b1;
                    cnt_enable <= 1'b0;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_race_arbiter.sv
// Testbench for puf_race_arbiter: directed and random measurements, with the
// expected response of each one queued at issue time and checked by a monitor.
module tb_puf_race_arbiter;

    localparam int CHAL_W = 8;
    localparam int TO_W   = 6;
    localparam int TO_LEN = (1 << TO_W) - 1;  // race cycles before a timeout
    localparam int EXP_W  = CHAL_W + 3 + 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic [CHAL_W-1:0] challenge;
    logic              busy;
    logic [CHAL_W-1:0] mux_sel;
    logic              cnt_reset;
    logic              cnt_enable;
    logic              finished_a;
    logic              finished_b;
    logic              resp_bit;
    logic              resp_tie;
    logic              resp_timeout;
    logic              resp_valid;
    logic              resp_ready;

    // Each entry packs {challenge, bit, tie, timeout, race_cycles}.
    logic [EXP_W-1:0] exp_q[$];

    int n_cmp;
    int n_fail;

    int race_cycles;
    int clr_cycles;
    int set_cycles;
    bit seen_valid;

    puf_race_arbiter #(
        .CHAL_W    (CHAL_W),
        .CLR_CYCLES(2),
        .SETTLE_CYC(4),
        .TIMEOUT_W (TO_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .challenge   (challenge),
        .busy        (busy),
        .mux_sel     (mux_sel),
        .cnt_reset   (cnt_reset),
        .cnt_enable  (cnt_enable),
        .finished_a  (finished_a),
        .finished_b  (finished_b),
        .resp_bit    (resp_bit),
        .resp_tie    (resp_tie),
        .resp_timeout(resp_timeout),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. A flag raised during race cycle k is visible to the
    // arbiter two cycles later, so it decides at race cycle k+2. A flag raised
    // during SETTLE (k==0) is already visible in the first race cycle.
    function automatic int decide_cycle(input int k);
        return (k == 0) ? 1 : k + 2;
    endfunction

    function automatic logic [EXP_W-1:0] model(input logic [CHAL_W-1:0] chal, input int ka, input int kb);
        int   da;
        int   db;
        int   first;
        logic b;
        logic t;
        logic to;
        int   len;
        da    = decide_cycle(ka);
        db    = decide_cycle(kb);
        first = (da < db) ? da : db;
        if (first > TO_LEN) begin
            b = 1'b0; t = 1'b0; to = 1'b1; len = TO_LEN;
        end else begin
            b = (da < db); t = (da == db); to = 1'b0; len = first;
        end
        return {chal, b, t, to, 8'(len)};
    endfunction

    // Monitor: phase lengths and race length, and the response while valid is high.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (reset) begin
            race_cycles = 0;
            clr_cycles  = 0;
            set_cycles  = 0;
            seen_valid  = 1'b0;
        end else begin
            if (busy && cnt_reset) clr_cycles++;
            if (busy && !cnt_reset && !cnt_enable && !resp_valid) set_cycles++;
            if (cnt_enable) begin
                if (race_cycles == 0) begin
                    check("clear_len", clr_cycles, 2);
                    check("settle_len", set_cycles, 4);
                end
                race_cycles++;
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("resp_mux_sel", mux_sel, e[EXP_W-1 -: CHAL_W]);
                    check("resp_bit", resp_bit, e[10]);
                    check("resp_tie", resp_tie, e[9]);
                    check("resp_timeout", resp_timeout, e[8]);
                    if (!seen_valid) begin
                        check("race_len", race_cycles, e[7:0]);
                        check("report_enable", cnt_enable, 0);
                        check("report_cnt_reset", cnt_reset, 0);
                        seen_valid = 1'b1;
                    end
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        seen_valid  = 1'b0;
                        race_cycles = 0;
                        clr_cycles  = 0;
                        set_cycles  = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        check("wait_idle", busy, 0);
    endtask

    // Driver: one measurement. ka/kb are the race cycles the flags rise in
    // (0 = during SETTLE, beyond the timeout = never). poke pulses start
    // while busy to show it is ignored.
    task automatic run_meas(input logic [CHAL_W-1:0] chal, input int ka, input int kb,
                            input int stall, input bit poke);
        int c;
        int guard;
        wait_idle();
        exp_q.push_back(model(chal, ka, kb));
        start     = 1'b1;
        challenge = chal;
        @(posedge clk); #1;
        start     = 1'b0;
        challenge = CHAL_W'($urandom);
        check("accept_busy", busy, 1);
        check("accept_mux_sel", mux_sel, chal);
        check("accept_cnt_reset", cnt_reset, 1);
        c     = 0;
        guard = 0;
        while (!resp_valid && guard < 300) begin
            if (busy && !cnt_reset && !cnt_enable) begin
                if (ka == 0) finished_a = 1'b1;
                if (kb == 0) finished_b = 1'b1;
            end
            if (cnt_enable) begin
                c++;
                if (c == ka) finished_a = 1'b1;
                if (c == kb) finished_b = 1'b1;
                start     = (poke && c == 3);
                challenge = CHAL_W'($urandom);
            end
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        check("resp_arrived", resp_valid, 1);
        repeat (stall) begin
            start = poke;
            @(posedge clk); #1;
        end
        start      = poke;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        start      = 1'b0;
        finished_a = 1'b0;
        finished_b = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_cnt_reset", cnt_reset, 1);
        check("idle_valid", resp_valid, 0);
        check("idle_mux_sel", mux_sel, chal);
    endtask

    // Reset asserted mid-race, away from the clock edge.
    task automatic reset_mid_race(input logic [CHAL_W-1:0] chal);
        int guard;
        wait_idle();
        start     = 1'b1;
        challenge = chal;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!cnt_enable && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_reached_race", cnt_enable, 1);
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_mux_sel", mux_sel, 0);
        check("rst_cnt_reset", cnt_reset, 1);
        check("rst_cnt_enable", cnt_enable, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_bit", {resp_bit, resp_tie, resp_timeout}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        challenge  = '0;
        finished_a = 1'b0;
        finished_b = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_cnt_reset", cnt_reset, 1);
        check("reset_outputs", {cnt_enable, resp_valid, resp_bit, resp_tie, resp_timeout}, 0);
        check("reset_mux_sel", mux_sel, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", {busy, cnt_reset}, 2'b01);

        run_meas(8'hA5, 10, 20, 0, 1'b0);     // A wins
        run_meas(8'h3C, 5, 5, 5, 1'b1);       // tie, stalled report, start pokes
        run_meas(8'h0F, 200, 200, 2, 1'b0);   // timeout
        run_meas(8'h81, 62, 62, 0, 1'b0);     // flags at decision 64: timeout wins
        run_meas(8'h7E, 61, 200, 1, 1'b0);    // flag decides exactly at the last cycle
        run_meas(8'h11, 0, 30, 0, 1'b0);      // A already high on entry
        run_meas(8'h22, 25, 0, 0, 1'b1);      // B already high on entry
        run_meas(8'h33, 0, 0, 0, 1'b0);       // both high on entry: tie

        for (int i = 0; i < 24; i++) begin
            run_meas(CHAL_W'($urandom), $urandom_range(0, 70), $urandom_range(0, 70),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        reset_mid_race(8'hC3);
        run_meas(8'h5A, 3, 9, 0, 1'b0);       // recovery after reset

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
